// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the scan decoder and display driver.
// Codes are active-high gfedcba; the blank code is the active-low all-off pattern.
package seg_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] BLANK_CODE = 7'h7F;

  // Index i holds the active-high glyph for hex digit i.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph lookup: active-low segments in, hex nibble out.
// valid_o marks a recognised glyph, blank_o marks all segments off.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       valid_o,
  output logic       blank_o
);

  always_comb begin
    nib_o   = '0;
    valid_o = 1'b0;
    blank_o = (seg_i == BLANK_CODE);
    for (int i = 0; i < 16; i++) begin
      if (~seg_i == GLYPH_TAB[i]) begin
        nib_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex display contents by watching a multiplexed 7-segment scan.
// Each settled dwell captures one digit; four captures publish a frame.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_DIGITS    = DIGITS
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   digit_select,
  input  logic [6:0]              led_select,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_strobe,
  output logic                    decode_error
);

  logic [NUM_DIGITS-1:0]        sel_q;
  logic [6:0]                   seg_q;
  logic [7:0]                   cnt_q, cnt_d;
  logic                         done_q, done_d;
  logic [NUM_DIGITS-1:0]        mask_q, mask_d;
  logic [NUM_DIGITS-1:0][3:0]   pend_nib_q, pend_nib_d;
  logic [NUM_DIGITS-1:0]        pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0][3:0]   value_q, value_d;
  logic [NUM_DIGITS-1:0]        dvld_q, dvld_d;
  logic                         strobe_q, strobe_d;
  logic                         err_q, err_d;

  logic       sel_chg;
  logic       one_cold;
  logic       cap;
  logic       frame_done;
  logic [1:0] slot;
  logic [3:0] g_nib;
  logic       g_vld;
  logic       g_blank;

  seg_glyph_decode u_glyph (
    .seg_i   (seg_q),
    .nib_o   (g_nib),
    .valid_o (g_vld),
    .blank_o (g_blank)
  );

  assign sel_chg    = (digit_select != sel_q);
  assign one_cold   = $onehot(~sel_q);
  assign frame_done = &mask_q;

  // done_q blocks a second capture when the counter saturates at the threshold.
  assign cap = one_cold && !done_q &&
               (cnt_q == 8'(SETTLE_CYCLES));

  always_comb begin
    slot = '0;
    if (one_cold) begin
      unique case (1'b1)
        !sel_q[0]: slot = 2'd0;
        !sel_q[1]: slot = 2'd1;
        !sel_q[2]: slot = 2'd2;
        !sel_q[3]: slot = 2'd3;
      endcase
    end
  end

  always_comb begin
    cnt_d  = sel_chg ? 8'd0 :
             (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    done_d = sel_chg ? 1'b0 : (done_q | cap);
    err_d  = cap && !g_vld && !g_blank;
  end

  // A capture landing with frame publication starts the next mask.
  always_comb begin
    mask_d     = frame_done ? '0 : mask_q;
    pend_nib_d = pend_nib_q;
    pend_vld_d = pend_vld_q;
    if (cap) begin
      mask_d[slot]     = 1'b1;
      pend_nib_d[slot] = g_nib;
      pend_vld_d[slot] = g_vld;
    end
  end

  always_comb begin
    value_d  = frame_done ? pend_nib_q : value_q;
    dvld_d   = frame_done ? pend_vld_q : dvld_q;
    strobe_d = frame_done;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q      <= '1;
      seg_q      <= BLANK_CODE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      mask_q     <= '0;
      pend_nib_q <= '0;
      pend_vld_q <= '0;
      value_q    <= '0;
      dvld_q     <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sel_q      <= digit_select;
      seg_q      <= led_select;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      mask_q     <= mask_d;
      pend_nib_q <= pend_nib_d;
      pend_vld_q <= pend_vld_d;
      value_q    <= value_d;
      dvld_q     <= dvld_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign value        = value_q;
  assign digit_valid  = dvld_q;
  assign frame_strobe = strobe_q;
  assign decode_error = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan scenarios plus random dwells
// scored against a dwell-level model of the display contents.
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit_select;
  logic [6:0]  led_select;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_strobe;
  logic        decode_error;

  int checks = 0;
  int errors = 0;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .NUM_DIGITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_select (digit_select),
    .led_select   (led_select),
    .value        (value),
    .digit_valid  (digit_valid),
    .frame_strobe (frame_strobe),
    .decode_error (decode_error)
  );

  always #5 clk = ~clk;

  // Active-high gfedcba glyphs for 0..F
  logic [6:0] ref_glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [3:0]  m_nib [4];
  logic [3:0]  m_vld;
  logic [3:0]  m_mask;
  logic [3:0]  prev_sel;
  logic [19:0] exp_q [$];
  logic [19:0] obs_q [$];
  int          exp_err, obs_err, hold_viol;
  logic [19:0] last_out;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (frame_strobe) obs_q.push_back({value, digit_valid});
      else if ({value, digit_valid} !== last_out) hold_viol++;
      if (decode_error) obs_err++;
    end
    last_out = {value, digit_valid};
  end

  function automatic logic [6:0] show(input int n);
    return ~ref_glyph[n];
  endfunction

  // {recognised, nibble}
  function automatic logic [4:0] ref_decode(input logic [6:0] seg_n);
    for (int i = 0; i < 16; i++)
      if (~seg_n == ref_glyph[i]) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_vld = 4'h0;
    m_mask = 4'h0;
    prev_sel = 4'hF;
  endtask

  // A dwell captures only if one-cold and long enough to reach the settle count.
  task automatic model_dwell(input logic [3:0] sel, input logic [6:0] seg, input int len);
    int slot;
    logic [4:0] d;
    if (len >= S + 1 && $countones(~sel) == 1) begin
      slot = 0;
      for (int i = 0; i < 4; i++) if (!sel[i]) slot = i;
      d = ref_decode(seg);
      m_nib[slot] = d[4] ? d[3:0] : 4'h0;
      m_vld[slot] = d[4];
      if (!d[4] && seg != 7'h7F) exp_err++;
      m_mask[slot] = 1'b1;
      if (m_mask == 4'hF) begin
        exp_q.push_back({m_nib[3], m_nib[2], m_nib[1], m_nib[0], m_vld});
        m_mask = 4'h0;
      end
    end
  endtask

  task automatic dwell(input logic [3:0] sel, input logic [6:0] seg, input int len);
    digit_select = sel;
    led_select   = seg;
    prev_sel     = sel;
    model_dwell(sel, seg, len);
    repeat (len) @(negedge clk);
  endtask

  task automatic flush();
    dwell(4'hF, 7'h7F, S + 6);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    obs_err = 0;
    exp_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    digit_select = 4'hF;
    led_select = 7'h7F;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (value !== 16'h0) begin
      errors++; $display("FAIL reset_value: got %h expected 0000", value);
    end
    checks++;
    if (digit_valid !== 4'h0) begin
      errors++; $display("FAIL reset_valid: got %h expected 0", digit_valid);
    end
    checks++;
    if (frame_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_strobe: got %b expected 0", frame_strobe);
    end
    checks++;
    if (decode_error !== 1'b0) begin
      errors++; $display("FAIL reset_error: got %b expected 0", decode_error);
    end
    reset = 1'b1;
    model_reset();
    hold_viol = 0;
    clear_obs();
    flush();
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL reset_idle_frames: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_basic();
    logic [19:0] fr;
    clear_obs();
    dwell(4'hE, show(3), 6);
    dwell(4'hD, show(0), 6);
    dwell(4'hB, show(15), 6);
    dwell(4'h7, show(1), 6);
    flush();
    fr = (obs_q.size() > 0) ? obs_q[0] : 20'hx;
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL basic_frames: got %0d expected 1", obs_q.size());
    end
    checks++;
    if (fr[19:4] !== 16'h1F03) begin
      errors++; $display("FAIL basic_value: got %h expected 1f03", fr[19:4]);
    end
    checks++;
    if (fr[3:0] !== 4'hF) begin
      errors++; $display("FAIL basic_valid: got %h expected f", fr[3:0]);
    end
    checks++;
    if (value !== 16'h1F03) begin
      errors++; $display("FAIL basic_hold: got %h expected 1f03", value);
    end
  endtask

  task automatic test_short_dwell();
    logic [19:0] fr;
    clear_obs();
    dwell(4'hE, show(0), 6);
    dwell(4'hD, show(1), 6);
    dwell(4'hB, show(2), 3);
    dwell(4'h7, show(3), 6);
    flush();
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL short_no_frame: got %0d expected 0", obs_q.size());
    end
    dwell(4'hB, show(2), 6);
    flush();
    fr = (obs_q.size() > 0) ? obs_q[0] : 20'hx;
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL short_frames: got %0d expected 1", obs_q.size());
    end
    checks++;
    if (fr !== {16'h3210, 4'hF}) begin
      errors++; $display("FAIL short_frame: got %h expected 3210f", fr);
    end
  endtask

  task automatic test_bad_glyph();
    logic [19:0] fr;
    clear_obs();
    dwell(4'hE, show(2), 6);
    dwell(4'hD, 7'b0110110, 6);
    dwell(4'hB, show(10), 6);
    dwell(4'h7, show(7), 6);
    flush();
    fr = (obs_q.size() > 0) ? obs_q[0] : 20'hx;
    checks++;
    if (obs_err != 1) begin
      errors++; $display("FAIL bad_err_pulses: got %0d expected 1", obs_err);
    end
    checks++;
    if (fr[3:0] !== 4'b1101) begin
      errors++; $display("FAIL bad_valid: got %b expected 1101", fr[3:0]);
    end
    checks++;
    if (fr[11:8] !== 4'h0) begin
      errors++; $display("FAIL bad_nibble: got %h expected 0", fr[11:8]);
    end
    checks++;
    if (fr[19:4] !== 16'h7A02) begin
      errors++; $display("FAIL bad_value: got %h expected 7a02", fr[19:4]);
    end
  endtask

  task automatic test_blank();
    logic [19:0] fr;
    clear_obs();
    dwell(4'hE, show(5), 6);
    dwell(4'hD, show(5), 6);
    dwell(4'hB, show(5), 6);
    dwell(4'h7, 7'h7F, 6);
    flush();
    fr = (obs_q.size() > 0) ? obs_q[0] : 20'hx;
    checks++;
    if (obs_err != 0) begin
      errors++; $display("FAIL blank_err: got %0d expected 0", obs_err);
    end
    checks++;
    if (fr !== {16'h0555, 4'b0111}) begin
      errors++; $display("FAIL blank_frame: got %h expected 05557", fr);
    end
  endtask

  task automatic test_not_onecold();
    logic [19:0] fr;
    clear_obs();
    dwell(4'hE, show(9), 6);
    dwell(4'hD, show(12), 6);
    dwell(4'b1010, show(8), 10);
    checks++;
    if (obs_q.size() != 0 || obs_err != 0) begin
      errors++;
      $display("FAIL twocold_quiet: got frames=%0d errs=%0d expected 0/0", obs_q.size(), obs_err);
    end
    dwell(4'hB, show(4), 6);
    dwell(4'h7, show(14), 6);
    flush();
    fr = (obs_q.size() > 0) ? obs_q[0] : 20'hx;
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL twocold_frames: got %0d expected 1", obs_q.size());
    end
    checks++;
    if (fr !== {16'hE4C9, 4'hF}) begin
      errors++; $display("FAIL twocold_frame: got %h expected e4c9f", fr);
    end
  endtask

  task automatic test_reset_midframe();
    logic [19:0] fr;
    clear_obs();
    dwell(4'hE, show(1), 6);
    dwell(4'hD, show(2), 6);
    #2 reset = 1'b0;
    digit_select = 4'hF;
    led_select = 7'h7F;
    #1;
    checks++;
    if (value !== 16'h0 || digit_valid !== 4'h0) begin
      errors++;
      $display("FAIL midreset_async: got %h/%h expected 0000/0", value, digit_valid);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) dwell(~(4'b0001 << i), show(8), 6);
    flush();
    fr = (obs_q.size() > 0) ? obs_q[0] : 20'hx;
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL midreset_frames: got %0d expected 1", obs_q.size());
    end
    checks++;
    if (fr !== {16'h8888, 4'hF}) begin
      errors++; $display("FAIL midreset_frame: got %h expected 8888f", fr);
    end
  endtask

  task automatic test_random();
    logic [3:0] sel;
    logic [6:0] seg;
    int r;
    clear_obs();
    hold_viol = 0;
    for (int n = 0; n < 120; n++) begin
      do begin
        if ($urandom_range(0, 4) != 0) sel = ~(4'b0001 << $urandom_range(0, 3));
        else sel = 4'($urandom);
      end while (sel == prev_sel);
      r = $urandom_range(0, 9);
      if (r < 7) seg = show($urandom_range(0, 15));
      else if (r == 7) seg = 7'h7F;
      else seg = 7'($urandom);
      dwell(sel, seg, $urandom_range(1, S + 3));
    end
    flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_frames: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_err != exp_err) begin
      errors++; $display("FAIL rand_errors: got %0d expected %0d", obs_err, exp_err);
    end
    checks++;
    if (hold_viol != 0) begin
      errors++; $display("FAIL rand_hold: got %0d changes expected 0", hold_viol);
    end
  endtask

  initial begin
    hold_viol = 0;
    obs_err = 0;
    exp_err = 0;
    model_reset();
    test_reset();
    test_basic();
    test_short_dwell();
    test_bad_glyph();
    test_blank();
    test_not_onecold();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
